// File: rtl/ram_sweep_pkg.sv
// Shared types and helpers for the self-clearing single-port RAM.
// Imported by ram_sweep (top) and ram_sweep_array (storage).
package ram_sweep_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 512;

    // S_CLEAR is encoded as 1 so busy is the state bit itself.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } ram_sweep_state_t;

    function automatic int addr_w_f(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_sweep_array.sv
// Plain word storage: one synchronous write port, one asynchronous read port.
// Kept free of control logic so it maps onto block or distributed RAM.
module ram_sweep_array
    import ram_sweep_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = addr_w_f(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; a reset port would stop RAM inference.
    // Clearing is done by the sweep sequencer in the top level instead.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ram_sweep.sv
// Single-port RAM with a hardware clear sweep after reset or on request.
// Define RAM_SWEEP_READ_REG_EN for a registered (one-cycle latency) read port.
module ram_sweep
    import ram_sweep_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = addr_w_f(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    ram_sweep_state_t  state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              addr_ok;
    logic              ptr_last;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  rdata;
    logic [WIDTH-1:0]  rd_word;

    assign addr_ok  = 32'(address) < DEPTH;
    assign ptr_last = 32'(clr_ptr_q) == (DEPTH - 1);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            S_CLEAR: begin
                if (clear) begin
                    clr_ptr_d = '0;
                end else if (ptr_last) begin
                    state_d   = S_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (clear) begin
                    state_d   = S_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Sweep owns the write port while busy; clear beats a coincident load.
    assign user_we   = (state_q == S_IDLE) && load && !clear && addr_ok;
    assign mem_we    = !reset && ((state_q == S_CLEAR) || user_we);
    assign mem_waddr = (state_q == S_CLEAR) ? clr_ptr_q : address;
    assign mem_wdata = (state_q == S_CLEAR) ? '0 : in;

    ram_sweep_array #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (address),
        .rdata_o (rdata)
    );

    assign busy    = (state_q == S_CLEAR);
    assign rd_word = (!busy && addr_ok) ? rdata : '0;

`ifdef RAM_SWEEP_READ_REG_EN
    logic [WIDTH-1:0] out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= rd_word;
        end
    end

    assign out = out_q;
`else
    assign out = rd_word;
`endif

endmodule

// File: tb/tb_ram_sweep.sv
// Self-checking bench for ram_sweep: 512-word scoreboarded instance plus a
// 300-word instance for the non-power-of-two corner cases.
module tb_ram_sweep;

    logic        clk = 1'b0;
    logic        rst, ld, clr;
    logic [8:0]  addr;
    logic [15:0] din, dout;
    logic        bsy;

    logic        r3, ld3;
    logic [8:0]  a3;
    logic [15:0] d3, out3;
    logic        busy3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] out;
        logic        busy;
    } exp_t;

    typedef struct {
        logic        ld;
        logic [8:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
        string       name;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] m_mem [512];
    logic        m_busy;
    int          m_ptr;
    logic [15:0] m_out_q;

    always #5 clk = ~clk;

    ram_sweep #(.WIDTH(16), .DEPTH(512)) dut (
        .clk(clk), .reset(rst), .load(ld), .address(addr), .in(din),
        .clear(clr), .out(dout), .busy(bsy)
    );

    ram_sweep #(.WIDTH(16), .DEPTH(300)) dut300 (
        .clk(clk), .reset(r3), .load(ld3), .address(a3), .in(d3),
        .clear(1'b0), .out(out3), .busy(busy3)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h @%0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle on the 512-word DUT: drive, score at negedge, advance model.
    task automatic step(input logic r, input logic l, input logic c,
                        input logic [8:0] a, input logic [15:0] d);
        exp_t e;
        rst = r; ld = l; clr = c; addr = a; din = d;
`ifdef RAM_SWEEP_READ_REG_EN
        e.out = m_out_q;
`else
        e.out = m_busy ? 16'h0000 : m_mem[a];
`endif
        e.busy = m_busy;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("step_out", {16'h0, dout}, {16'h0, e.out});
            check("step_busy", {31'h0, bsy}, {31'h0, e.busy});
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_busy = 1'b1; m_ptr = 0; m_out_q = 16'h0;
        end else begin
            m_out_q = m_busy ? 16'h0 : m_mem[a];
            if (m_busy) begin
                if (c) begin
                    m_ptr = 0;
                end else begin
                    m_mem[m_ptr] = 16'h0;
                    if (m_ptr == 511) begin
                        m_busy = 1'b0; m_ptr = 0;
                    end else begin
                        m_ptr++;
                    end
                end
            end else if (c) begin
                m_busy = 1'b1; m_ptr = 0;
            end else if (l) begin
                m_mem[a] = d;
            end
        end
    endtask

    // Idle read; after the edge the output reflects mem[a] in both read builds.
    task automatic rd512(input string name, input logic [8:0] a, input logic [15:0] exp);
        step(1'b0, 1'b0, 1'b0, a, 16'h0);
        check(name, {16'h0, dout}, {16'h0, exp});
    endtask

    // Counts edges from now until busy falls; loads are attempted throughout.
    task automatic count_sweep(input string name, input int exp_n, input logic [8:0] a,
                               input logic [15:0] d);
        int n = 0;
        while (bsy && n < 2000) begin
            step(1'b0, 1'b1, 1'b0, a, d);
            n++;
        end
        check(name, n, exp_n);
    endtask

    task automatic rd300(input string name, input logic [8:0] a, input logic [15:0] exp);
        a3 = a;
        ld3 = 1'b0;
`ifdef RAM_SWEEP_READ_REG_EN
        @(posedge clk);
`endif
        #1;
        check(name, {16'h0, out3}, {16'h0, exp});
    endtask

    initial begin
        vec_t vecs[10];
        int   n;

        vecs[0] = '{1'b1, 9'd2,   16'hABCD, 16'hABCD, "wr_2"};
        vecs[1] = '{1'b0, 9'd2,   16'h0000, 16'hABCD, "rd_2"};
        vecs[2] = '{1'b0, 9'd0,   16'h0000, 16'h0000, "rd_0"};
        vecs[3] = '{1'b1, 9'd511, 16'h1234, 16'h1234, "wr_511"};
        vecs[4] = '{1'b0, 9'd510, 16'h0000, 16'h0000, "rd_510"};
        vecs[5] = '{1'b0, 9'd511, 16'h0000, 16'h1234, "rd_511"};
        vecs[6] = '{1'b1, 9'd100, 16'h0F0F, 16'h0F0F, "wr_100"};
        vecs[7] = '{1'b1, 9'd100, 16'hF0F0, 16'hF0F0, "ovw_100"};
        vecs[8] = '{1'b0, 9'd255, 16'h0000, 16'h0000, "rd_255"};
        vecs[9] = '{1'b0, 9'd2,   16'h0000, 16'hABCD, "rd_2_again"};

        rst = 1'b1; ld = 1'b0; clr = 1'b0; addr = '0; din = '0;
        r3 = 1'b1; ld3 = 1'b0; a3 = '0; d3 = '0;
        foreach (m_mem[i]) m_mem[i] = 16'h0;

        // Reset held two cycles; the first edge only establishes a known state.
        @(posedge clk);
        #1;
        m_busy = 1'b1; m_ptr = 0; m_out_q = 16'h0;
        step(1'b1, 1'b0, 1'b0, 9'd0, 16'h0);
        check("rst_busy", {31'h0, bsy}, 32'd1);
        check("rst_out", {16'h0, dout}, 32'd0);
        count_sweep("sweep_len_reset", 512, 9'd7, 16'h7777);
        rd512("post_rst_0", 9'd0, 16'h0000);
        rd512("post_rst_255", 9'd255, 16'h0000);
        rd512("post_rst_511", 9'd511, 16'h0000);
        rd512("load_in_sweep_7", 9'd7, 16'h0000);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, vecs[i].ld, 1'b0, vecs[i].a, vecs[i].d);
            rd512(vecs[i].name, vecs[i].a, vecs[i].exp);
        end

        // Clear with a coincident load: the load must be dropped.
        step(1'b0, 1'b1, 1'b1, 9'd3, 16'h5555);
        check("clear_busy", {31'h0, bsy}, 32'd1);
        count_sweep("sweep_len_clear", 512, 9'd9, 16'h9999);
        rd512("clr_2", 9'd2, 16'h0000);
        rd512("clr_3", 9'd3, 16'h0000);
        rd512("clr_511", 9'd511, 16'h0000);
        rd512("clr_9", 9'd9, 16'h0000);

        // Reset at sweep cycle 100 restarts the full sweep.
        step(1'b0, 1'b0, 1'b1, 9'd0, 16'h0);
        for (int i = 0; i < 99; i++) step(1'b0, 1'b1, 1'b0, 9'd4, 16'h4444);
        step(1'b1, 1'b0, 1'b0, 9'd0, 16'h0);
        count_sweep("sweep_len_mid_reset", 512, 9'd4, 16'h4444);
        rd512("mid_rst_4", 9'd4, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 9'd4, 16'h4444);
        rd512("idle_wr_4", 9'd4, 16'h4444);

        // Non-power-of-two depth.
        @(posedge clk);
        #1;
        r3 = 1'b0;
        n = 0;
        while (busy3 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("d300_sweep_len", n, 300);
        ld3 = 1'b1; a3 = 9'd300; d3 = 16'hFFFF;
        @(posedge clk);
        #1;
        rd300("d300_oob_300", 9'd300, 16'h0000);
        ld3 = 1'b1; a3 = 9'd299; d3 = 16'hBEEF;
        @(posedge clk);
        #1;
        rd300("d300_wr_299", 9'd299, 16'hBEEF);
        rd300("d300_rd_0", 9'd0, 16'h0000);
        rd300("d300_rd_44", 9'd44, 16'h0000);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
